// File: rtl/sprite_pkg.sv
// Shared types for the sprite byte-stream link: the record layout, its byte
// count on the wire, and the transmitter FSM states.
package sprite_pkg;

   localparam int SPRITE_RECORD_BYTES = 6;

   typedef struct packed {
      logic [7:0]  id;
      logic [15:0] x;
      logic [15:0] y;
      logic [7:0]  scale;
   } sprite_record_t;

   typedef enum logic [2:0] {
      RESYNC_LO,
      RESYNC_HI,
      IDLE,
      SEND_LO,
      SEND_HI,
      GAP_LO,
      GAP_HI
   } sprite_tx_state_t;

   // Wire order: id, x hi, x lo, y hi, y lo, scale.
   function automatic logic [7:0] sprite_byte(input sprite_record_t rec, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = rec.id;
         3'd1:    b = rec.x[15:8];
         3'd2:    b = rec.x[7:0];
         3'd3:    b = rec.y[15:8];
         3'd4:    b = rec.y[7:0];
         3'd5:    b = rec.scale;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sprite_stream_tx_if.sv
// Record input port of the sprite transmitter.
// A record transfers on a rising clock edge where rec_valid && rec_ready; the
// master holds rec_valid and the fields steady until that edge.
interface sprite_stream_tx_if;
   logic        rec_valid;
   logic        rec_ready;
   logic [7:0]  rec_id;
   logic [15:0] rec_x;
   logic [15:0] rec_y;
   logic [7:0]  rec_scale;

   modport master (output rec_valid, rec_id, rec_x, rec_y, rec_scale, input rec_ready);
   modport slave  (input rec_valid, rec_id, rec_x, rec_y, rec_scale, output rec_ready);
endinterface

// File: rtl/sprite_record_fifo.sv
// Synchronous FIFO of sprite records; pointers carry one extra wrap bit so
// full and empty are distinguishable without a counter.
module sprite_record_fifo
   import sprite_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_push,
   input  sprite_record_t i_data,
   output logic           o_full,
   input  logic           i_pop,
   output sprite_record_t o_data,
   output logic           o_empty
);

   localparam int AW = $clog2(DEPTH);

   sprite_record_t r_mem [DEPTH];
   logic [AW:0]    r_wr_ptr;
   logic [AW:0]    r_rd_ptr;
   logic           w_do_push;
   logic           w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/sprite_stream_tx.sv
// Sprite stream transmitter: queues records and serialises each one as six
// strobed bytes, with a resync pulse after reset and optional gap pulses.
module sprite_stream_tx
   import sprite_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_PULSES = 1
) (
   input  logic             clock,
   input  logic             reset,
   sprite_stream_tx_if.slave rec,
   output logic             data_clk,
   output logic             enqueue_en,
   output logic [7:0]       enqueue_data,
   output logic             busy,
   output logic [15:0]      records_sent,
   output sprite_tx_state_t dbg_state
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int GW = (GAP_PULSES > 1) ? $clog2(GAP_PULSES) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_PULSES > 0) ? GAP_PULSES - 1 : 0);
   localparam logic [2:0]    LAST_IDX   = 3'(SPRITE_RECORD_BYTES - 1);

   sprite_tx_state_t r_state, w_state_nx;
   logic [PW-1:0]    r_phase, w_phase_nx;
   logic [2:0]       r_idx, w_idx_nx;
   logic [GW-1:0]    r_gap, w_gap_nx;
   sprite_record_t   r_rec;
   logic [15:0]      r_sent;
   logic             r_data_clk, r_en;
   logic [7:0]       r_data;
   logic             w_pop, w_sent_inc, w_phase_done, w_sending;
   logic             w_full, w_empty;
   sprite_record_t   w_fifo_in, w_fifo_out;

   assign w_fifo_in     = {rec.rec_id, rec.rec_x, rec.rec_y, rec.rec_scale};
   assign rec.rec_ready = !w_full;

   sprite_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .i_push  (rec.rec_valid),
      .i_data  (w_fifo_in),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_data  (w_fifo_out),
      .o_empty (w_empty)
   );

   assign w_phase_done = (r_phase == PHASE_LAST);
   assign w_sending    = (r_state == SEND_LO) || (r_state == SEND_HI);

   always_comb begin
      w_state_nx = r_state;
      w_phase_nx = w_phase_done ? '0 : r_phase + PW'(1);
      w_idx_nx   = r_idx;
      w_gap_nx   = r_gap;
      w_pop      = 1'b0;
      w_sent_inc = 1'b0;
      case (r_state)
         RESYNC_LO: if (w_phase_done) w_state_nx = RESYNC_HI;
         RESYNC_HI: if (w_phase_done) w_state_nx = IDLE;
         IDLE: begin
            w_phase_nx = '0;
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_idx_nx   = '0;
               w_state_nx = SEND_LO;
            end
         end
         SEND_LO: if (w_phase_done) w_state_nx = SEND_HI;
         SEND_HI: begin
            if (w_phase_done) begin
               if (r_idx != LAST_IDX) begin
                  w_idx_nx   = r_idx + 3'd1;
                  w_state_nx = SEND_LO;
               end else begin
                  w_sent_inc = 1'b1;
                  if (GAP_PULSES > 0) begin
                     w_gap_nx   = '0;
                     w_state_nx = GAP_LO;
                  end else if (!w_empty) begin
                     w_pop      = 1'b1;
                     w_idx_nx   = '0;
                     w_state_nx = SEND_LO;
                  end else begin
                     w_state_nx = IDLE;
                  end
               end
            end
         end
         GAP_LO: if (w_phase_done) w_state_nx = GAP_HI;
         GAP_HI: begin
            if (w_phase_done) begin
               if (r_gap != GAP_LAST) begin
                  w_gap_nx   = r_gap + GW'(1);
                  w_state_nx = GAP_LO;
               end else if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_idx_nx   = '0;
                  w_state_nx = SEND_LO;
               end else begin
                  w_state_nx = IDLE;
               end
            end
         end
         default: w_state_nx = RESYNC_LO;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= RESYNC_LO;
         r_phase <= '0;
         r_idx   <= '0;
         r_gap   <= '0;
         r_rec   <= '0;
         r_sent  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_phase <= w_phase_nx;
         r_idx   <= w_idx_nx;
         r_gap   <= w_gap_nx;
         if (w_pop)      r_rec  <= w_fifo_out;
         if (w_sent_inc) r_sent <= r_sent + 16'd1;
      end
   end

   // Line outputs are registered one cycle behind the FSM so strobe, enable
   // and byte always move together on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_data_clk <= 1'b0;
         r_en       <= 1'b0;
         r_data     <= 8'h00;
      end else begin
         r_data_clk <= (r_state == RESYNC_HI) || (r_state == SEND_HI) || (r_state == GAP_HI);
         r_en       <= w_sending;
         r_data     <= w_sending ? sprite_byte(r_rec, r_idx) : 8'h00;
      end
   end

   assign data_clk     = r_data_clk;
   assign enqueue_en   = r_en;
   assign enqueue_data = r_data;
   assign busy         = (r_state != IDLE) || !w_empty;
   assign records_sent = r_sent;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_sprite_stream_tx.sv
// Bench for sprite_stream_tx: three instances (default, no gap, fast strobe),
// each feeding a byte-level receiver model that rebuilds records.
module tb_sprite_stream_tx;
   import sprite_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic [2:0] rst = 3'b111;
   int         cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500_000;
      $display("FAIL watchdog: sim time expired");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   logic [2:0]  drv_v = '0;
   logic [7:0]  drv_id [3];
   logic [15:0] drv_x [3];
   logic [15:0] drv_y [3];
   logic [7:0]  drv_sc [3];
   logic [2:0]  rdy, dclk, en, busy;
   logic [7:0]  dat [3];
   logic [15:0] sent [3];
   sprite_tx_state_t st_a, st_b, st_c;

   sprite_stream_tx_if rif_a ();
   sprite_stream_tx_if rif_b ();
   sprite_stream_tx_if rif_c ();

   assign rif_a.rec_valid = drv_v[0];
   assign rif_a.rec_id    = drv_id[0];
   assign rif_a.rec_x     = drv_x[0];
   assign rif_a.rec_y     = drv_y[0];
   assign rif_a.rec_scale = drv_sc[0];
   assign rdy[0]          = rif_a.rec_ready;
   assign rif_b.rec_valid = drv_v[1];
   assign rif_b.rec_id    = drv_id[1];
   assign rif_b.rec_x     = drv_x[1];
   assign rif_b.rec_y     = drv_y[1];
   assign rif_b.rec_scale = drv_sc[1];
   assign rdy[1]          = rif_b.rec_ready;
   assign rif_c.rec_valid = drv_v[2];
   assign rif_c.rec_id    = drv_id[2];
   assign rif_c.rec_x     = drv_x[2];
   assign rif_c.rec_y     = drv_y[2];
   assign rif_c.rec_scale = drv_sc[2];
   assign rdy[2]          = rif_c.rec_ready;

   sprite_stream_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .GAP_PULSES(1)) dut_a (
      .clock(clk), .reset(rst[0]), .rec(rif_a), .data_clk(dclk[0]), .enqueue_en(en[0]),
      .enqueue_data(dat[0]), .busy(busy[0]), .records_sent(sent[0]), .dbg_state(st_a));
   sprite_stream_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .GAP_PULSES(0)) dut_b (
      .clock(clk), .reset(rst[1]), .rec(rif_b), .data_clk(dclk[1]), .enqueue_en(en[1]),
      .enqueue_data(dat[1]), .busy(busy[1]), .records_sent(sent[1]), .dbg_state(st_b));
   sprite_stream_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .GAP_PULSES(1)) dut_c (
      .clock(clk), .reset(rst[2]), .rec(rif_c), .data_clk(dclk[2]), .enqueue_en(en[2]),
      .enqueue_data(dat[2]), .busy(busy[2]), .records_sent(sent[2]), .dbg_state(st_c));

   // ---------------- scoreboard ----------------
   logic [49:0] exp_q [$];
   logic [49:0] rx_q [$];
   int          rx_t [$];
   int          n_total = 0;
   int          n_bad = 0;

   // Receiver model plus stability monitor, one per instance.
   for (genvar g = 0; g < 3; g++) begin : g_rx
      int          cnt = 0;
      int          en0_cnt = 0;
      int          en1_cnt = 0;
      int          viol = 0;
      logic [47:0] sh = '0;
      logic        pdclk = 1'b0;
      logic [8:0]  pout = '0;
      always @(posedge dclk[g]) begin
         if (!en[g]) begin
            cnt = 0;
            en0_cnt++;
         end else begin
            sh = {sh[39:0], dat[g]};
            cnt++;
            en1_cnt++;
            if (cnt == SPRITE_RECORD_BYTES) begin
               rx_q.push_back({2'(g), sh});
               rx_t.push_back(cyc);
               cnt = 0;
            end
         end
      end
      always @(negedge clk) begin
         if (dclk[g] && pdclk && ({en[g], dat[g]} != pout)) viol++;
         pdclk = dclk[g];
         pout  = {en[g], dat[g]};
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic push_rec(input int d, input logic [47:0] r, input int budget);
      logic ok;
      logic done;
      done      = 1'b0;
      drv_v[d]  = 1'b1;
      drv_id[d] = r[47:40];
      drv_x[d]  = r[39:24];
      drv_y[d]  = r[23:8];
      drv_sc[d] = r[7:0];
      for (int i = 0; i < budget; i++) begin
         ok = rdy[d];
         @(negedge clk);
         if (ok) begin
            exp_q.push_back({2'(d), r});
            done = 1'b1;
            break;
         end
      end
      drv_v[d] = 1'b0;
      if (!done) chk("push_timeout", done, 1);
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (rx_q.size() >= n) break;
         @(negedge clk);
      end
      chk("rx_count", rx_q.size(), n);
   endtask

   task automatic wait_idle(input int d, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy[d]) break;
         @(negedge clk);
      end
      chk("idle_wait", busy[d], 0);
   endtask

   task automatic check_sb(input string tag);
      while (exp_q.size() > 0) begin
         if (rx_q.size() == 0) begin
            chk({tag, "_missing"}, 0, exp_q.size());
            exp_q.delete();
         end else begin
            chk(tag, rx_q.pop_front(), exp_q.pop_front());
         end
      end
      chk({tag, "_extra"}, rx_q.size(), 0);
   endtask

   function automatic logic [47:0] rec_t3(input int i);
      return {8'(8'h10 + i), 16'(16'hA000 + i), 16'(16'h5000 + i * 16'h0101), 8'(i + 1)};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      logic [47:0] r;
      for (int d = 0; d < 3; d++) begin
         drv_id[d] = '0; drv_x[d] = '0; drv_y[d] = '0; drv_sc[d] = '0;
      end

      // Reset state and resync pulse.
      repeat (3) @(negedge clk);
      chk("rst_dclk", dclk[0], 0);
      chk("rst_en", en[0], 0);
      chk("rst_data", dat[0], 0);
      chk("rst_sent", sent[0], 0);
      chk("rst_busy", busy[0], 1);
      chk("rst_ready", rdy[0], 1);
      rst = 3'b000;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         case (k)
            4: chk("rs_clk_k4", dclk[0], 0);
            5: chk("rs_clk_k5", dclk[0], 1);
            7: chk("rs_busy_k7", busy[0], 1);
            8: begin
               chk("rs_busy_k8", busy[0], 0);
               chk("rs_clk_k8", dclk[0], 1);
               chk("rs_state_k8", st_a, IDLE);
            end
            9: chk("rs_clk_k9", dclk[0], 0);
            default: ;
         endcase
      end
      chk("rs_en0_pulses", g_rx[0].en0_cnt, 1);
      chk("rs_en1_pulses", g_rx[0].en1_cnt, 0);
      chk("rs_ready", rdy[0], 1);

      // Single record with one gap pulse.
      push_rec(0, 48'h05_0123_0456_02, 10);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         case (k)
            1: chk("t2_en_k1", en[0], 0);
            2: begin
               chk("t2_en_k2", en[0], 1);
               chk("t2_byte0", dat[0], 8'h05);
               chk("t2_clk_k2", dclk[0], 0);
            end
            5: chk("t2_clk_k5", dclk[0], 0);
            6: chk("t2_clk_k6", dclk[0], 1);
            14: chk("t2_byte1", {dclk[0], dat[0]}, 9'h101);
            46: chk("t2_byte5", {dclk[0], en[0], dat[0]}, 10'h302);
            48: chk("t2_sent_k48", sent[0], 0);
            49: chk("t2_sent_k49", sent[0], 1);
            54: chk("t2_gap", {dclk[0], en[0], dat[0]}, 10'h200);
            56: chk("t2_busy_k56", busy[0], 1);
            57: chk("t2_busy_k57", busy[0], 0);
            default: ;
         endcase
      end
      chk("t2_en1_pulses", g_rx[0].en1_cnt, 6);
      chk("t2_en0_pulses", g_rx[0].en0_cnt, 2);
      check_sb("t2_rec");

      // FIFO full: one record in flight plus four queued, then one more.
      rx_t.delete();
      push_rec(0, rec_t3(0), 10);
      t0 = cyc;
      for (int i = 1; i < 5; i++) push_rec(0, rec_t3(i), 10);
      chk("t3_fill_cyc", cyc - t0, 4);
      chk("t3_full_ready", rdy[0], 0);
      push_rec(0, rec_t3(5), 200);
      chk("t3_accept_cyc", cyc - t0, 58);
      wait_rx(6, 700);
      wait_idle(0, 200);
      if (rx_t.size() == 6)
         for (int i = 1; i < 6; i++) chk("t3_spacing", rx_t[i] - rx_t[i-1], 56);
      check_sb("t3_rec");
      chk("t3_sent", sent[0], 7);
      chk("t3_en0_pulses", g_rx[0].en0_cnt, 8);

      // No gap pulses: two records stream back-to-back.
      rx_t.delete();
      push_rec(1, 48'h21_1111_2222_33, 10);
      push_rec(1, 48'h22_4444_5555_66, 10);
      wait_rx(2, 300);
      wait_idle(1, 100);
      if (rx_t.size() == 2) chk("t4_spacing", rx_t[1] - rx_t[0], 48);
      check_sb("t4_rec");
      chk("t4_en1_pulses", g_rx[1].en1_cnt, 12);
      chk("t4_en0_pulses", g_rx[1].en0_cnt, 1);
      chk("t4_sent", sent[1], 2);

      // Reset in the middle of a record, with a second record queued.
      push_rec(0, 48'h0A_1122_3344_55, 10);
      push_rec(0, 48'h0B_6666_7777_88, 10);
      repeat (30) @(negedge clk);
      chk("t5_pre", {dclk[0], en[0], dat[0]}, 10'h333);
      rst[0] = 1'b1;
      #1;
      chk("t5_clr", {dclk[0], en[0], dat[0]}, 10'h000);
      chk("t5_sent_clr", sent[0], 0);
      chk("t5_ready", rdy[0], 1);
      chk("t5_busy", busy[0], 1);
      repeat (2) @(negedge clk);
      rst[0] = 1'b0;
      exp_q.delete();
      chk("t5_no_partial", rx_q.size(), 0);
      push_rec(0, 48'h07_0010_0020_01, 10);
      wait_rx(1, 200);
      wait_idle(0, 100);
      check_sb("t5_rec");
      chk("t5_sent", sent[0], 1);

      // Random traffic on the fast-strobe instance.
      for (int i = 0; i < 20; i++) begin
         r = {16'($urandom), 32'($urandom)};
         repeat ($urandom_range(0, 30)) @(negedge clk);
         push_rec(2, r, 300);
      end
      wait_rx(20, 2000);
      wait_idle(2, 200);
      check_sb("t6_rec");
      chk("t6_sent", sent[2], 20);
      chk("t6_en1_pulses", g_rx[2].en1_cnt, 120);
      chk("t6_en0_pulses", g_rx[2].en0_cnt, 21);
      chk("stable_a", g_rx[0].viol, 0);
      chk("stable_b", g_rx[1].viol, 0);
      chk("stable_c", g_rx[2].viol, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
